// File: rtl/freq_scaler_pkg.sv
// rtl/freq_scaler_pkg.sv - shared types, default divide table and helpers for freq_scaler
package freq_scaler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } fs_state_t;

    // Ratios 1,2,4,5,7,10 -> 100,50,25,20,14.286,10 MHz from a 100 MHz clock.
    localparam logic [47:0] FS_DEFAULT_DIV_TABLE = 48'h0A0705040201;

    function automatic int unsigned ceil_half(input int unsigned d);
        return (d + 32'd1) / 32'd2;
    endfunction

endpackage

// File: rtl/freq_div_core.sv
// rtl/freq_div_core.sv - period counter producing clk_en and a registered divided clock
module freq_div_core
    import freq_scaler_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             wrap,
    output logic             clk_en,
    output logic             clk_out
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] eff_div;

    assign wrap    = (cnt == div - 1'b1);
    assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
    // load is only raised on a wrap cycle, so the new ratio starts cleanly at cnt 0
    assign eff_div = load ? load_div : div;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            clk_en  <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            clk_en  <= wrap;
            clk_out <= (32'(cnt_nxt) < ceil_half(32'(eff_div)));
        end
    end

endmodule

// File: rtl/freq_scaler.sv
// rtl/freq_scaler.sv - glitch-free divide-level controller; switch_count under FREQ_SCALER_STATS_EN
module freq_scaler
    import freq_scaler_pkg::*;
#(
    parameter int                          NUM_LEVELS  = 6,
    parameter int                          DIV_W       = 8,
    parameter logic [NUM_LEVELS*DIV_W-1:0] DIV_TABLE   = FS_DEFAULT_DIV_TABLE,
    parameter int                          RESET_LEVEL = 1,
    parameter int                          LVL_W       = $clog2(NUM_LEVELS)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic [LVL_W-1:0] req_level,
    output logic             req_ready,
    output logic             ack,
    output logic             err,
    output logic [LVL_W-1:0] cur_level,
    output logic             clk_en,
    output logic             clk_out
`ifdef FREQ_SCALER_STATS_EN
    ,
    output logic [15:0]      switch_count
`endif
);

    localparam logic [LVL_W:0]   NUM_LEVELS_L = (LVL_W+1)'(NUM_LEVELS);
    localparam logic [LVL_W-1:0] RST_LVL      = LVL_W'(RESET_LEVEL);

    function automatic logic [DIV_W-1:0] div_of(input logic [LVL_W-1:0] lvl);
        logic [DIV_W-1:0] d;
        d = DIV_TABLE[int'(lvl)*DIV_W +: DIV_W];
        if ({1'b0, lvl} >= NUM_LEVELS_L) begin
            d = DIV_W'(1);
        end
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    fs_state_t        state;
    logic [LVL_W-1:0] pend_level;
    logic [DIV_W-1:0] div_r;
    logic             wrap;
    logic             req_in_range;
    logic             req_change;
    logic             load;
    logic [LVL_W-1:0] load_level;
    logic [DIV_W-1:0] load_div;

    assign req_ready    = (state == IDLE);
    assign req_in_range = ({1'b0, req_level} < NUM_LEVELS_L);
    assign req_change   = req_valid && req_in_range && (req_level != cur_level);
    // A change request landing on the wrap cycle switches at once instead of waiting a full period.
    assign load         = wrap && ((state == PEND) || ((state == IDLE) && req_change));
    assign load_level   = (state == PEND) ? pend_level : req_level;
    assign load_div     = div_of(load_level);

    freq_div_core #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .div      (div_r),
        .load     (load),
        .load_div (load_div),
        .wrap     (wrap),
        .clk_en   (clk_en),
        .clk_out  (clk_out)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pend_level <= RST_LVL;
            cur_level  <= RST_LVL;
            div_r      <= div_of(RST_LVL);
            ack        <= 1'b0;
            err        <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!req_in_range) begin
                            err <= 1'b1;
                        end else if (req_level == cur_level) begin
                            ack <= 1'b1;
                        end else if (wrap) begin
                            cur_level <= req_level;
                            div_r     <= load_div;
                            ack       <= 1'b1;
                        end else begin
                            pend_level <= req_level;
                            state      <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (wrap) begin
                        cur_level <= pend_level;
                        div_r     <= load_div;
                        ack       <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FREQ_SCALER_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            switch_count <= '0;
        end else if (load && (switch_count != 16'hFFFF)) begin
            switch_count <= switch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_freq_scaler.sv
// tb/tb_freq_scaler.sv - scoreboard bench for freq_scaler against a period-level reference model
module tb_freq_scaler;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic [2:0] req_level;
    logic       req_ready, ack, err, clk_en, clk_out;
    logic [2:0] cur_level;
`ifdef FREQ_SCALER_STATS_EN
    logic [15:0] switch_count;
`endif

    always #5 clk = ~clk;

    freq_scaler dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_level (req_level),
        .req_ready (req_ready),
        .ack       (ack),
        .err       (err),
        .cur_level (cur_level),
        .clk_en    (clk_en),
`ifdef FREQ_SCALER_STATS_EN
        .switch_count (switch_count),
`endif
        .clk_out   (clk_out)
    );

    typedef struct {
        int en; int out; int ack; int err; int rdy; int lvl; int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   tbl[6] = '{1, 2, 4, 5, 7, 10};

    // Reference model: position inside the current period, level in effect, pending target.
    int m_lvl, m_div, m_pos, m_pend_lvl, m_cnt;
    bit m_pend;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step(input bit rn, input bit v, input int l);
        exp_t e;
        bit   boundary, sw;
        int   nl;
        @(negedge clk);
        resetn    = rn;
        req_valid = v;
        req_level = 3'(l);
        e = '{default: 0};
        if (!rn) begin
            m_lvl = 1; m_div = tbl[1]; m_pos = 0; m_pend = 0; m_cnt = 0;
            e.rdy = 1; e.lvl = 1;
        end else begin
            boundary = (m_pos + 1 == m_div);
            sw = 0;
            nl = m_lvl;
            if (!m_pend && v) begin
                if (l >= 6)            e.err = 1;
                else if (l == m_lvl)   e.ack = 1;
                else if (boundary)     begin sw = 1; nl = l; end
                else                   begin m_pend = 1; m_pend_lvl = l; end
            end else if (m_pend && boundary) begin
                sw = 1; nl = m_pend_lvl; m_pend = 0;
            end
            e.en  = boundary;
            m_pos = boundary ? 0 : m_pos + 1;
            if (sw) begin
                m_lvl = nl; m_div = tbl[nl]; e.ack = 1;
                if (m_cnt < 65535) m_cnt++;
            end
            e.out = (m_pos < (m_div + 1) / 2);
            e.rdy = !m_pend;
            e.lvl = m_lvl;
            e.cnt = m_cnt;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("clk_en",    clk_en,    mon_e.en);
            chk("clk_out",   clk_out,   mon_e.out);
            chk("ack",       ack,       mon_e.ack);
            chk("err",       err,       mon_e.err);
            chk("req_ready", req_ready, mon_e.rdy);
            chk("cur_level", cur_level, mon_e.lvl);
`ifdef FREQ_SCALER_STATS_EN
            chk("switch_count", switch_count, mon_e.cnt);
`endif
        end
    end

    task automatic align(input int p);
        int n;
        n = 0;
        while (m_pos != p && n < 40) begin
            step(1, 0, 0);
            n++;
        end
        chk("align_pos", m_pos, p);
    endtask

    task automatic request(input int l, output int lat);
        lat = 1;
        step(1, 1, l);
        while (!ack && !err && lat < 30) begin
            step(1, 0, 0);
            lat++;
        end
    endtask

    task automatic period(output int per, output int hi);
        int n;
        n = 0;
        while (!clk_en && n < 40) begin
            step(1, 0, 0);
            n++;
        end
        per = 0;
        hi  = 0;
        do begin
            step(1, 0, 0);
            per++;
            if (clk_out) hi++;
        end while (!clk_en && per < 40);
    endtask

    initial begin
        int lat, per, hi, first;
        bit hv;
        int hl;
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_level = 3'd0;

        repeat (3) step(0, 0, 0);
        chk("rst_cur_level", cur_level, 1);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_clk_out", clk_out, 0);

        first = 0;
        for (int c = 1; c <= 40; c++) begin
            step(1, 0, 0);
            if (clk_en && first == 0) first = c;
        end
        chk("first_clk_en_cycle", first, 2);

        align(0);
        request(5, lat);
        chk("lvl5_ack_latency", lat, 2);
        period(per, hi);
        chk("lvl5_period", per, 10);
        chk("lvl5_high", hi, 5);

        request(6, lat);
        chk("invalid_err_latency", lat, 1);
        chk("invalid_err", err, 1);
        chk("invalid_no_ack", ack, 0);
        step(1, 0, 0);
        chk("invalid_err_once", err, 0);
        period(per, hi);
        chk("invalid_period_kept", per, 10);

        align(3);
        request(3, lat);
        chk("lvl3_ack_latency", lat, 7);
        period(per, hi);
        chk("lvl3_period", per, 5);
        chk("lvl3_high", hi, 3);

        align(0);
        step(1, 1, 0);
        chk("pend_not_ready", req_ready, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("abort_cur_level", cur_level, 1);
        chk("abort_ready", req_ready, 1);
        chk("abort_no_ack", ack, 0);
`ifdef FREQ_SCALER_STATS_EN
        chk("abort_switch_count", switch_count, 0);
`endif

        request(2, lat);
        chk("stat_ack_a", ack, 1);
        request(4, lat);
        chk("stat_ack_b", ack, 1);
        request(0, lat);
        chk("stat_ack_c", ack, 1);
        request(0, lat);
        chk("same_level_ack_latency", lat, 1);
`ifdef FREQ_SCALER_STATS_EN
        chk("stat_switch_count", switch_count, 3);
`endif

        hv = 0;
        hl = 0;
        for (int c = 0; c < 2000; c++) begin
            bit rn;
            bit acc;
            rn = ($urandom_range(0, 199) != 0);
            if (!hv && $urandom_range(0, 3) == 0) begin
                hv = 1;
                hl = $urandom_range(0, 7);
            end
            acc = !m_pend;
            step(rn, hv, hl);
            if (acc || !rn) hv = 0;
        end
        repeat (3) step(1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
